centroid_tracker: RTL and testbench

Parametrised successor to the single-target tracking controller. Consumes a raster-order pixel stream carrying per-channel "found" flags (one flag per colour target). Accumulates coordinate sums and hit counts for every channel over a frame, then computes each channel's integer centroid with one shared sequential divider. Datapath and control are integrated. Sits between the colour-threshold stage and the drag/stamp logic.

---
 rtl/centroid_tracker.sv | 220 ++++++++++++++++++++++
 tb/tb_centroid_tracker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/centroid_tracker.sv
`timescale 1ns/1ps
// Multi-channel centroid tracker: per-frame coordinate sums and hit counts per
// colour channel, then integer centroids from one shared restoring divider.
module centroid_tracker #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int CHANNELS  = 2,
  parameter int MIN_COUNT = 1,
  localparam int XW = $clog2(H_RES),
  localparam int YW = $clog2(V_RES),
  localparam int CW = $clog2(H_RES*V_RES+1),
  localparam int QW = (XW > YW) ? XW : YW,
  localparam int SW = CW + QW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   pix_valid,
  input  logic                   pix_sof,
  input  logic [CHANNELS-1:0]    pix_found,
  output logic [CHANNELS*XW-1:0] pos_x,
  output logic [CHANNELS*YW-1:0] pos_y,
  output logic [CHANNELS-1:0]    pos_valid,
  output logic                   done,
  output logic                   busy
);

  localparam int DIW = $clog2(2*CHANNELS+1);
  localparam int BW  = $clog2(SW);
  localparam logic [XW-1:0]  X_LAST   = XW'(H_RES-1);
  localparam logic [YW-1:0]  Y_LAST   = YW'(V_RES-1);
  localparam logic [BW-1:0]  BIT_LAST = BW'(SW-1);
  localparam logic [DIW-1:0] DIV_DONE = DIW'(2*CHANNELS);
  localparam logic [CW-1:0]  MIN_CNT  = CW'(MIN_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SCAN, S_DIVIDE} state_t;

  state_t         state_q;
  logic [XW-1:0]  x_q;
  logic [YW-1:0]  y_q;
  logic [SW-1:0]  x_sum_q [CHANNELS];
  logic [SW-1:0]  y_sum_q [CHANNELS];
  logic [CW-1:0]  cnt_q   [CHANNELS];

  logic [DIW-1:0] div_idx_q;
  logic [BW-1:0]  bit_cnt_q;
  logic [CW:0]    rem_q;
  logic [QW-2:0]  quo_q;
  logic [XW-1:0]  qx_q [CHANNELS];
  logic [YW-1:0]  qy_q [CHANNELS];

  logic [XW-1:0]  pos_x_q [CHANNELS];
  logic [YW-1:0]  pos_y_q [CHANNELS];
  logic [CHANNELS-1:0] pos_valid_q;
  logic           done_q;
  logic           busy_q;

  logic           x_last, at_origin, frame_end, start_frame;
  logic [SW-1:0]  div_num;
  logic [CW-1:0]  div_den;
  logic           div_in_bit;
  logic [CW:0]    rem_sh, rem_diff, rem_d;
  logic           rem_ge;
  logic [QW-1:0]  quo_d;

  always_comb begin
    x_last      = (x_q == X_LAST);
    at_origin   = (x_q == '0) && (y_q == '0);
    frame_end   = x_last && (y_q == Y_LAST);
    // A sof anywhere but the origin during SCAN restarts the frame
    start_frame = pix_valid && pix_sof &&
                  (((state_q == S_ARMED) && enable) ||
                   ((state_q == S_SCAN) && !at_origin));
  end

  always_comb begin
    div_num = '0;
    div_den = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(div_idx_q) == 2*c) begin
        div_num = x_sum_q[c];
        div_den = cnt_q[c];
      end
      if (int'(div_idx_q) == 2*c+1) begin
        div_num = y_sum_q[c];
        div_den = cnt_q[c];
      end
    end
    div_in_bit = div_num[BIT_LAST - bit_cnt_q];
    rem_sh     = {rem_q[CW-1:0], div_in_bit};
    rem_diff   = rem_sh - {1'b0, div_den};
    // rem_q[CW] stays 0 whenever the divisor is non-zero
    rem_ge     = rem_q[CW] | (rem_sh >= {1'b0, div_den});
    rem_d      = rem_ge ? rem_diff : rem_sh;
    quo_d      = {quo_q, rem_ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      div_idx_q   <= '0;
      bit_cnt_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      pos_valid_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        x_sum_q[c] <= '0;
        y_sum_q[c] <= '0;
        cnt_q[c]   <= '0;
        qx_q[c]    <= '0;
        qy_q[c]    <= '0;
        pos_x_q[c] <= '0;
        pos_y_q[c] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          x_q <= '0;
          y_q <= '0;
          for (int c = 0; c < CHANNELS; c++) begin
            x_sum_q[c] <= '0;
            y_sum_q[c] <= '0;
            cnt_q[c]   <= '0;
          end
          if (enable) state_q <= S_ARMED;
        end
        S_ARMED: begin
          if (!enable) state_q <= S_IDLE;
        end
        S_SCAN: begin
          if (pix_valid && !start_frame) begin
            for (int c = 0; c < CHANNELS; c++) begin
              if (pix_found[c]) begin
                x_sum_q[c] <= x_sum_q[c] + SW'(x_q);
                y_sum_q[c] <= y_sum_q[c] + SW'(y_q);
                cnt_q[c]   <= cnt_q[c] + CW'(1);
              end
            end
            if (frame_end) begin
              state_q   <= S_DIVIDE;
              x_q       <= '0;
              y_q       <= '0;
              div_idx_q <= '0;
              bit_cnt_q <= '0;
              rem_q     <= '0;
              quo_q     <= '0;
            end else if (x_last) begin
              x_q <= '0;
              y_q <= y_q + YW'(1);
            end else begin
              x_q <= x_q + XW'(1);
            end
          end
        end
        S_DIVIDE: begin
          if (div_idx_q == DIV_DONE) begin
            for (int c = 0; c < CHANNELS; c++) begin
              if ((cnt_q[c] != '0) && (cnt_q[c] >= MIN_CNT)) begin
                pos_x_q[c]     <= qx_q[c];
                pos_y_q[c]     <= qy_q[c];
                pos_valid_q[c] <= 1'b1;
              end else begin
                pos_valid_q[c] <= 1'b0;
              end
            end
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= enable ? S_ARMED : S_IDLE;
          end else if (bit_cnt_q == BIT_LAST) begin
            for (int c = 0; c < CHANNELS; c++) begin
              if (int'(div_idx_q) == 2*c)   qx_q[c] <= quo_d[XW-1:0];
              if (int'(div_idx_q) == 2*c+1) qy_q[c] <= quo_d[YW-1:0];
            end
            rem_q     <= '0;
            quo_q     <= '0;
            bit_cnt_q <= '0;
            div_idx_q <= div_idx_q + DIW'(1);
          end else begin
            rem_q     <= rem_d;
            quo_q     <= quo_d[QW-2:0];
            bit_cnt_q <= bit_cnt_q + BW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Frame start: the sof pixel is (0,0), so it contributes only to counts
      if (start_frame) begin
        for (int c = 0; c < CHANNELS; c++) begin
          x_sum_q[c] <= '0;
          y_sum_q[c] <= '0;
          cnt_q[c]   <= CW'(pix_found[c]);
        end
        x_q     <= XW'(1);
        y_q     <= '0;
        state_q <= S_SCAN;
        busy_q  <= 1'b1;
      end
    end
  end

  always_comb begin
    pos_x = '0;
    pos_y = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pos_x[c*XW +: XW] = pos_x_q[c];
      pos_y[c*YW +: YW] = pos_y_q[c];
    end
  end

  assign pos_valid = pos_valid_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_centroid_tracker.sv
`timescale 1ns/1ps
// Directed bench for centroid_tracker at 16x8, two channels; a second
// instance with MIN_COUNT=4 shares the stimulus.
module tb_centroid_tracker;
  localparam int H = 16;
  localparam int V = 8;
  localparam int C = 2;
  localparam int XW = 4;
  localparam int YW = 3;
  localparam int LAT = 2*C*12 + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic pix_valid = 1'b0;
  logic pix_sof = 1'b0;
  logic [C-1:0] pix_found = '0;

  logic [C*XW-1:0] pos_x, pos_x4;
  logic [C*YW-1:0] pos_y, pos_y4;
  logic [C-1:0]    pos_valid, pos_valid4;
  logic            done, done4, busy, busy4;

  int n_chk = 0;
  int n_err = 0;
  int done_seen = 0;
  logic [C-1:0] fmap [H*V];

  centroid_tracker #(.H_RES(H), .V_RES(V), .CHANNELS(C), .MIN_COUNT(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_found(pix_found), .pos_x(pos_x), .pos_y(pos_y),
    .pos_valid(pos_valid), .done(done), .busy(busy));

  centroid_tracker #(.H_RES(H), .V_RES(V), .CHANNELS(C), .MIN_COUNT(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_found(pix_found), .pos_x(pos_x4), .pos_y(pos_y4),
    .pos_valid(pos_valid4), .done(done4), .busy(busy4));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int px(input int c);
    return int'(pos_x[c*XW +: XW]);
  endfunction
  function automatic int py(input int c);
    return int'(pos_y[c*YW +: YW]);
  endfunction
  function automatic int px4(input int c);
    return int'(pos_x4[c*XW +: XW]);
  endfunction
  function automatic int py4(input int c);
    return int'(pos_y4[c*YW +: YW]);
  endfunction

  task automatic clear_map();
    for (int i = 0; i < H*V; i++) fmap[i] = '0;
  endtask

  task automatic hit(input int c, input int x, input int y);
    fmap[y*H+x][c] = 1'b1;
  endtask

  task automatic send(input int n, input bit gaps, input int drop_at, input int exp_busy);
    for (int p = 0; p < n; p++) begin
      if (gaps && (p % 9) == 4) begin
        pix_valid = 1'b0; pix_sof = 1'b1; pix_found = '1;
        @(posedge clk); #1;
        if (done) done_seen++;
      end
      if (p == drop_at) enable = 1'b0;
      pix_valid = 1'b1;
      pix_sof   = (p == 0);
      pix_found = fmap[p];
      @(posedge clk); #1;
      if (done) done_seen++;
      if (p == 0) check("busy_scan", busy, exp_busy);
    end
    pix_valid = 1'b0; pix_sof = 1'b0; pix_found = '0;
  endtask

  task automatic finish_frame(input string tag);
    int cyc;
    cyc = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done) begin
        cyc = k;
        break;
      end
    end
    check({tag, "_latency"}, cyc, LAT);
    check({tag, "_busy_low"}, busy, 0);
    @(posedge clk); #1;
    check({tag, "_done_fall"}, done, 0);
  endtask

  task automatic quiet(input string tag, input int n);
    int seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (done || done4) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_pos_x", int'(pos_x), 0);
    check("rst_pos_y", int'(pos_y), 0);
    check("rst_valid", int'(pos_valid), 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("armed_busy", busy, 0);

    // single hit
    clear_map(); hit(0, 5, 3);
    send(H*V, 1'b0, -1, 1);
    finish_frame("t1");
    check("t1_x0", px(0), 5);
    check("t1_y0", py(0), 3);
    check("t1_valid", int'(pos_valid), 1);
    check("t1_x1", px(1), 0);
    check("t1_y1", py(1), 0);

    // every pixel on ch1
    clear_map();
    for (int i = 0; i < H*V; i++) fmap[i] = 2'b10;
    send(H*V, 1'b0, -1, 1);
    finish_frame("t2");
    check("t2_x1", px(1), 7);
    check("t2_y1", py(1), 3);
    check("t2_valid", int'(pos_valid), 2);
    check("t2_x0_held", px(0), 5);
    check("t2_y0_held", py(0), 3);

    // hold on loss, with gapped pixel stream
    clear_map(); hit(0, 2, 2); hit(0, 4, 6);
    send(H*V, 1'b1, -1, 1);
    finish_frame("t3a");
    check("t3a_x0", px(0), 3);
    check("t3a_y0", py(0), 4);
    check("t3a_valid", int'(pos_valid), 1);
    check("t3a_x1_held", px(1), 7);
    clear_map();
    send(H*V, 1'b0, -1, 1);
    finish_frame("t3b");
    check("t3b_x0", px(0), 3);
    check("t3b_y0", py(0), 4);
    check("t3b_valid", int'(pos_valid), 0);

    // resync at raster position 37
    done_seen = 0;
    clear_map(); hit(0, 1, 1);
    send(37, 1'b0, -1, 1);
    clear_map(); hit(0, 6, 2); hit(0, 8, 4); hit(1, 10, 5);
    send(H*V, 1'b0, -1, 1);
    check("t4_no_done", done_seen, 0);
    finish_frame("t4");
    check("t4_x0", px(0), 7);
    check("t4_y0", py(0), 3);
    check("t4_x1", px(1), 10);
    check("t4_y1", py(1), 5);
    check("t4_valid", int'(pos_valid), 3);

    // reset ten cycles into DIVIDE
    clear_map(); hit(0, 5, 3);
    send(H*V, 1'b0, -1, 1);
    repeat (10) @(posedge clk);
    #1;
    check("t6_busy_div", busy, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_pos_x", int'(pos_x), 0);
    check("t6_rst_pos_y", int'(pos_y), 0);
    check("t6_rst_valid", int'(pos_valid), 0);
    check("t6_rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    quiet("t6_no_done", 80);
    check("t6_valid_after", int'(pos_valid), 0);

    // enable drops mid-frame; corner pixels
    clear_map(); hit(0, 15, 7); hit(1, 0, 0);
    send(H*V, 1'b0, 10, 1);
    finish_frame("t6b");
    check("t6b_x0", px(0), 15);
    check("t6b_y0", py(0), 7);
    check("t6b_x1", px(1), 0);
    check("t6b_y1", py(1), 0);
    check("t6b_valid", int'(pos_valid), 3);
    clear_map(); hit(0, 3, 3);
    send(H*V, 1'b0, -1, 0);
    quiet("t6b_idle_quiet", 80);
    check("t6b_idle_x0", px(0), 15);
    check("t6b_idle_busy", busy, 0);

    // MIN_COUNT=4 instance
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_map(); hit(0, 1, 1); hit(0, 3, 1); hit(0, 1, 3); hit(0, 3, 3);
    send(H*V, 1'b0, -1, 1);
    finish_frame("t5a");
    check("t5a_x0", px4(0), 2);
    check("t5a_y0", py4(0), 2);
    check("t5a_valid", int'(pos_valid4), 1);
    clear_map(); hit(0, 10, 5); hit(0, 12, 5); hit(0, 11, 6);
    send(H*V, 1'b0, -1, 1);
    finish_frame("t5b");
    check("t5b_valid4", int'(pos_valid4), 0);
    check("t5b_x0_held", px4(0), 2);
    check("t5b_y0_held", py4(0), 2);
    check("t5b_valid1", int'(pos_valid), 1);
    check("t5b_x0_min1", px(0), 11);
    check("t5b_y0_min1", py(0), 5);
    clear_map(); hit(0, 8, 4); hit(0, 10, 4); hit(0, 8, 6); hit(0, 10, 6);
    send(H*V, 1'b0, -1, 1);
    finish_frame("t5c");
    check("t5c_x0", px4(0), 9);
    check("t5c_y0", py4(0), 5);
    check("t5c_valid", int'(pos_valid4), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
